// File: rtl/uart_rx_controller.sv
// uart_rx_controller: UART receive frame sequencer, stepped once per UCLK oversampling tick.
// Optional build macro UART_RX_BREAK_DETECT_EN adds the break_detected output and a BREAK hold state.
module uart_rx_controller #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  UCLK,
   input  logic                  reset,
   input  logic                  serial_data_in,
   input  logic [4:0]            prescale,
   input  logic                  parity_en,
   input  logic                  parity_type,
   input  logic                  sampled_bit,
   output logic                  sampler_enable,
   output logic [4:0]            edge_count,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  parity_error,
   output logic                  stop_error,
`ifdef UART_RX_BREAK_DETECT_EN
   output logic                  break_detected,
`endif
   output logic                  busy
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_RX_BREAK_DETECT_EN
      , S_BREAK
`endif
   } state_t;

   state_t                state, state_nxt;
   logic [4:0]            psc_q;
   logic                  par_en_q, par_type_q;
   logic [2:0]            bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  xor_acc, par_flag;
   logic                  decision, start_det;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                  seen_one;
`endif

   // psc_q is never below 6, so the decision point can never fire in IDLE
   assign decision  = (edge_count == psc_q - 5'd1);
   assign start_det = (state == S_IDLE) && !serial_data_in;

   always_ff @(posedge UCLK or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      busy           = (state != S_IDLE);
      sampler_enable = (state != S_IDLE);
      case (state)
         S_IDLE:   if (!serial_data_in) state_nxt = S_START;
         S_START:  if (decision) state_nxt = sampled_bit ? S_IDLE : S_DATA;
         S_DATA:   if (decision && bit_cnt == LAST_BIT) state_nxt = par_en_q ? S_PARITY : S_STOP;
         S_PARITY: if (decision) state_nxt = S_STOP;
         S_STOP: begin
            if (decision) begin
               state_nxt = S_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
               if (!sampled_bit && !seen_one) state_nxt = S_BREAK;
`endif
            end
         end
`ifdef UART_RX_BREAK_DETECT_EN
         S_BREAK:  if (decision && sampled_bit) state_nxt = S_IDLE;
`endif
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge UCLK or negedge reset) begin
      if (!reset) begin
         edge_count   <= '0;
         psc_q        <= 5'd8;
         par_en_q     <= 1'b0;
         par_type_q   <= 1'b0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         xor_acc      <= 1'b0;
         par_flag     <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         seen_one       <= 1'b0;
         break_detected <= 1'b0;
`endif
      end else begin
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         break_detected <= 1'b0;
`endif
         if (state == S_IDLE) begin
            edge_count <= start_det ? 5'd1 : 5'd0;
            if (start_det) begin
               psc_q      <= (prescale < 5'd6) ? 5'd8 : prescale;
               par_en_q   <= parity_en;
               par_type_q <= parity_type;
               bit_cnt    <= '0;
               xor_acc    <= 1'b0;
               par_flag   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
               seen_one   <= 1'b0;
`endif
            end
         end else begin
            edge_count <= decision ? 5'd0 : edge_count + 5'd1;
            if (decision) begin
               case (state)
                  S_DATA: begin
                     shift_reg[bit_cnt] <= sampled_bit;
                     xor_acc            <= xor_acc ^ sampled_bit;
                     bit_cnt            <= bit_cnt + 3'd1;
`ifdef UART_RX_BREAK_DETECT_EN
                     seen_one           <= seen_one | sampled_bit;
`endif
                  end
                  S_PARITY: begin
                     if (sampled_bit != (xor_acc ^ par_type_q)) par_flag <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                     seen_one <= seen_one | sampled_bit;
`endif
                  end
                  S_STOP: begin
                     if (sampled_bit && !par_flag) begin
                        data_out   <= shift_reg;
                        data_valid <= 1'b1;
                     end else begin
                        parity_error <= par_flag;
`ifdef UART_RX_BREAK_DETECT_EN
                        // an all-zero frame is a line break, not a framing error
                        if (!sampled_bit && !seen_one) break_detected <= 1'b1;
                        else                           stop_error     <= !sampled_bit;
`else
                        stop_error <= !sampled_bit;
`endif
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: directed scenarios plus randomized frames
// checked against a frame-level model (bit list -> expected pulses, latency and counters).
module tb_uart_rx_controller;
   localparam int DW = 8;

   logic          UCLK = 1'b0, reset = 1'b0, serial_data_in = 1'b1, sampled_bit = 1'b1;
   logic          parity_en = 1'b0, parity_type = 1'b0;
   logic [4:0]    prescale = 5'd8;
   logic          sampler_enable, data_valid, parity_error, stop_error, busy;
   logic [4:0]    edge_count;
   logic [DW-1:0] data_out;
`ifdef UART_RX_BREAK_DETECT_EN
   logic          break_detected;
`endif

   int n_checks = 0, n_fail = 0;
   logic [DW-1:0] last_good = '0;

   always #5 UCLK = ~UCLK;

   uart_rx_controller #(.DATA_WIDTH(DW)) dut (
      .UCLK(UCLK), .reset(reset), .serial_data_in(serial_data_in), .prescale(prescale),
      .parity_en(parity_en), .parity_type(parity_type), .sampled_bit(sampled_bit),
      .sampler_enable(sampler_enable), .edge_count(edge_count), .data_out(data_out),
      .data_valid(data_valid), .parity_error(parity_error), .stop_error(stop_error),
`ifdef UART_RX_BREAK_DETECT_EN
      .break_detected(break_detected),
`endif
      .busy(busy)
   );

   bit            line_q[$];
   int            dv_c[$], pe_c[$], se_c[$], bd_c[$];
   logic [DW-1:0] dv_d[$];
   logic [4:0]    ec_log[$];
   logic          bz_log[$], en_log[$];

   function automatic int eff(input int p);
      return (p < 6) ? 8 : p;
   endfunction

   // line waveform of one frame: start, data LSB first, optional parity, stop
   task automatic push_frame(input logic [DW-1:0] d, input int p, input bit pe, input bit pbit, input bit stop);
      int pf;
      pf = eff(p);
      repeat (pf) line_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) repeat (pf) line_q.push_back(d[i]);
      if (pe) repeat (pf) line_q.push_back(pbit);
      repeat (pf) line_q.push_back(stop);
   endtask

   // cycle c: observe outputs of cycle c, then drive the line for cycle c
   task automatic run(input int ncyc, input bit scramble);
      dv_c.delete(); pe_c.delete(); se_c.delete(); bd_c.delete(); dv_d.delete();
      ec_log.delete(); bz_log.delete(); en_log.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge UCLK);
         if (data_valid === 1'b1) begin dv_c.push_back(c); dv_d.push_back(data_out); end
         if (parity_error === 1'b1) pe_c.push_back(c);
         if (stop_error === 1'b1) se_c.push_back(c);
`ifdef UART_RX_BREAK_DETECT_EN
         if (break_detected === 1'b1) bd_c.push_back(c);
`endif
         ec_log.push_back(edge_count); bz_log.push_back(busy); en_log.push_back(sampler_enable);
         serial_data_in = (c < line_q.size()) ? line_q[c] : 1'b1;
         sampled_bit    = serial_data_in;
         if (scramble && c > 0) begin
            prescale    = 5'($urandom_range(0, 31));
            parity_en   = 1'($urandom);
            parity_type = 1'($urandom);
         end
      end
      line_q.delete();
   endtask

   // first cycle whose edge_count/busy/sampler_enable disagree with a frame ending at t_end, or -1
   function automatic int timing_bad(input int t_end, input int pf);
      logic [4:0] e;
      logic       b;
      for (int c = 0; c <= t_end; c++) begin
         if (c >= ec_log.size()) return c;
         e = (c < t_end) ? 5'(c % pf) : 5'd0;
         b = (c > 0 && c < t_end);
         if (ec_log[c] !== e || bz_log[c] !== b || en_log[c] !== b) return c;
      end
      return -1;
   endfunction

   task automatic test_reset;
      serial_data_in = 1'b0; sampled_bit = 1'b0;
      repeat (3) @(negedge UCLK);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (sampler_enable !== 1'b0) begin n_fail++; $display("FAIL reset_sampler_en got=%b exp=0", sampler_enable); end
      n_checks++; if (edge_count !== 5'd0) begin n_fail++; $display("FAIL reset_edge got=%0d exp=0", edge_count); end
      n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_out); end
      n_checks++; if ({data_valid, parity_error, stop_error} !== 3'b000) begin
         n_fail++; $display("FAIL reset_pulses got=%b exp=000", {data_valid, parity_error, stop_error}); end
      serial_data_in = 1'b1; sampled_bit = 1'b1;
      @(negedge UCLK); reset = 1'b1;
   endtask

   task automatic test_basic;
      prescale = 5'd8; parity_en = 1'b0;
      push_frame(8'hA5, 8, 0, 0, 1);
      run(90, 0);
      n_checks++; if (dv_c.size() !== 1 || dv_c[0] !== 80) begin
         n_fail++; $display("FAIL basic_dv_cycle got_n=%0d first=%0d exp=80", dv_c.size(), dv_c.size() ? dv_c[0] : -1); end
      n_checks++; if (dv_d.size() == 0 || dv_d[0] !== 8'hA5) begin
         n_fail++; $display("FAIL basic_data got=%h exp=a5", dv_d.size() ? dv_d[0] : 8'hxx); end
      n_checks++; if (pe_c.size() + se_c.size() !== 0) begin
         n_fail++; $display("FAIL basic_err_pulses got=%0d exp=0", pe_c.size() + se_c.size()); end
      n_checks++; if (timing_bad(80, 8) !== -1) begin
         n_fail++; $display("FAIL basic_timing bad_cycle=%0d exp=-1", timing_bad(80, 8)); end
      last_good = 8'hA5;
   endtask

   task automatic test_parity;
      logic pgood;
      prescale = 5'd16; parity_en = 1'b1; parity_type = 1'b0;
      pgood = ^8'h3C ^ 1'b0;
      push_frame(8'h3C, 16, 1, pgood, 1);
      run(180, 0);
      n_checks++; if (dv_c.size() !== 1 || dv_c[0] !== 176) begin
         n_fail++; $display("FAIL parity_good_dv got_n=%0d first=%0d exp=176", dv_c.size(), dv_c.size() ? dv_c[0] : -1); end
      n_checks++; if (pe_c.size() !== 0) begin n_fail++; $display("FAIL parity_good_pe got=%0d exp=0", pe_c.size()); end
      last_good = 8'h3C;
      push_frame(8'h3C, 16, 1, ~pgood, 1);
      run(180, 0);
      n_checks++; if (pe_c.size() !== 1 || pe_c[0] !== 176) begin
         n_fail++; $display("FAIL parity_bad_pe got_n=%0d first=%0d exp=176", pe_c.size(), pe_c.size() ? pe_c[0] : -1); end
      n_checks++; if (dv_c.size() + se_c.size() !== 0) begin
         n_fail++; $display("FAIL parity_bad_other got=%0d exp=0", dv_c.size() + se_c.size()); end
      n_checks++; if (data_out !== last_good) begin n_fail++; $display("FAIL parity_bad_hold got=%h exp=%h", data_out, last_good); end
   endtask

   task automatic test_stop_error;
      prescale = 5'd8; parity_en = 1'b0;
      push_frame(8'h55, 8, 0, 0, 0);
      run(90, 0);
      n_checks++; if (se_c.size() !== 1 || se_c[0] !== 80) begin
         n_fail++; $display("FAIL stop_err_cycle got_n=%0d first=%0d exp=80", se_c.size(), se_c.size() ? se_c[0] : -1); end
      n_checks++; if (dv_c.size() + pe_c.size() !== 0) begin
         n_fail++; $display("FAIL stop_err_other got=%0d exp=0", dv_c.size() + pe_c.size()); end
      n_checks++; if (bz_log[80] !== 1'b0) begin n_fail++; $display("FAIL stop_err_busy got=%b exp=0", bz_log[80]); end
      n_checks++; if (data_out !== last_good) begin n_fail++; $display("FAIL stop_err_hold got=%h exp=%h", data_out, last_good); end
   endtask

   task automatic test_glitch;
      prescale = 5'd8; parity_en = 1'b0;
      repeat (3) line_q.push_back(1'b0);
      run(20, 0);
      n_checks++; if (timing_bad(8, 8) !== -1) begin
         n_fail++; $display("FAIL glitch_timing bad_cycle=%0d exp=-1", timing_bad(8, 8)); end
      n_checks++; if (dv_c.size() + pe_c.size() + se_c.size() + bd_c.size() !== 0) begin
         n_fail++; $display("FAIL glitch_pulses got=%0d exp=0", dv_c.size() + pe_c.size() + se_c.size()); end
   endtask

   task automatic test_back_to_back;
      prescale = 5'd8; parity_en = 1'b0;
      push_frame(8'h01, 8, 0, 0, 1);
      push_frame(8'hFE, 8, 0, 0, 1);
      run(170, 0);
      n_checks++; if (dv_c.size() !== 2 || dv_c[0] !== 80 || dv_c[1] !== 160) begin
         n_fail++; $display("FAIL b2b_cycles got_n=%0d exp=2 at 80,160", dv_c.size()); end
      n_checks++; if (dv_d.size() !== 2 || dv_d[0] !== 8'h01 || dv_d[1] !== 8'hFE) begin
         n_fail++; $display("FAIL b2b_data got_n=%0d exp=01,fe", dv_d.size()); end
      last_good = 8'hFE;
   endtask

   task automatic test_reset_mid;
      prescale = 5'd8; parity_en = 1'b0;
      push_frame(8'h81, 8, 0, 0, 1);
      run(40, 0);
      @(negedge UCLK);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
      #2 reset = 1'b0; serial_data_in = 1'b1; sampled_bit = 1'b1;
      #1;
      n_checks++; if ({busy, sampler_enable, edge_count} !== 7'd0) begin
         n_fail++; $display("FAIL rstmid_state got=%b exp=0", {busy, sampler_enable, edge_count}); end
      n_checks++; if ({data_out, data_valid, parity_error, stop_error} !== 11'd0) begin
         n_fail++; $display("FAIL rstmid_outputs got=%h exp=0", {data_out, data_valid, parity_error, stop_error}); end
      repeat (3) @(negedge UCLK);
      reset = 1'b1;
      push_frame(8'h81, 8, 0, 0, 1);
      run(90, 0);
      n_checks++; if (dv_c.size() !== 1 || dv_c[0] !== 80 || dv_d[0] !== 8'h81) begin
         n_fail++; $display("FAIL rstmid_recover got_n=%0d exp=1 at 80 data 81", dv_c.size()); end
      last_good = 8'h81;
   endtask

   task automatic test_min_prescale;
      int ps[2];
      ps[0] = 5; ps[1] = 6;
      foreach (ps[k]) begin
         prescale = 5'(ps[k]); parity_en = 1'b0;
         push_frame(8'h5A, ps[k], 0, 0, 1);
         run(10 * eff(ps[k]) + 4, 0);
         n_checks++; if (dv_c.size() !== 1 || dv_c[0] !== 10 * eff(ps[k])) begin
            n_fail++; $display("FAIL minpsc_%0d_dv got_n=%0d exp=%0d", ps[k], dv_c.size(), 10 * eff(ps[k])); end
         n_checks++; if (timing_bad(10 * eff(ps[k]), eff(ps[k])) !== -1) begin
            n_fail++; $display("FAIL minpsc_%0d_timing bad_cycle=%0d", ps[k], timing_bad(10 * eff(ps[k]), eff(ps[k]))); end
      end
      last_good = 8'h5A;
   endtask

   task automatic test_random;
      for (int f = 0; f < 10; f++) begin
         logic [DW-1:0] d;
         int p, pf, t;
         bit pe, pt, pbit, stop, ok_par;
         d    = DW'($urandom_range(1, 255));
         p    = $urandom_range(2, 20);
         pe   = 1'($urandom); pt = 1'($urandom);
         pbit = (^d) ^ pt ^ ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 3) != 0);
         pf   = eff(p);
         t    = (2 + DW + int'(pe)) * pf;
         ok_par = !pe || (pbit == ((^d) ^ pt));
         prescale = 5'(p); parity_en = pe; parity_type = pt;
         push_frame(d, p, pe, pbit, stop);
         run(t + 4, 1);
         if (stop && ok_par) last_good = d;
         n_checks++; if (dv_c.size() !== int'(stop && ok_par) || (dv_c.size() > 0 && dv_c[0] !== t)) begin
            n_fail++; $display("FAIL rand%0d_dv got_n=%0d exp_n=%0d at %0d", f, dv_c.size(), int'(stop && ok_par), t); end
         n_checks++; if (pe_c.size() !== int'(!ok_par) || (pe_c.size() > 0 && pe_c[0] !== t)) begin
            n_fail++; $display("FAIL rand%0d_pe got_n=%0d exp_n=%0d", f, pe_c.size(), int'(!ok_par)); end
         n_checks++; if (se_c.size() !== int'(!stop) || (se_c.size() > 0 && se_c[0] !== t)) begin
            n_fail++; $display("FAIL rand%0d_se got_n=%0d exp_n=%0d", f, se_c.size(), int'(!stop)); end
         n_checks++; if (data_out !== last_good) begin
            n_fail++; $display("FAIL rand%0d_data got=%h exp=%h", f, data_out, last_good); end
         n_checks++; if (timing_bad(t, pf) !== -1) begin
            n_fail++; $display("FAIL rand%0d_timing bad_cycle=%0d p=%0d", f, timing_bad(t, pf), p); end
      end
   endtask

   task automatic test_break;
      prescale = 5'd8; parity_en = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      repeat (200) line_q.push_back(1'b0);
      run(215, 0);
      n_checks++; if (bd_c.size() !== 1 || bd_c[0] !== 80) begin
         n_fail++; $display("FAIL break_pulse got_n=%0d first=%0d exp=80", bd_c.size(), bd_c.size() ? bd_c[0] : -1); end
      n_checks++; if (se_c.size() + dv_c.size() !== 0) begin
         n_fail++; $display("FAIL break_other got=%0d exp=0", se_c.size() + dv_c.size()); end
      n_checks++; if (bz_log[207] !== 1'b1 || bz_log[208] !== 1'b0) begin
         n_fail++; $display("FAIL break_exit got=%b%b exp=10", bz_log[207], bz_log[208]); end
`else
      repeat (80) line_q.push_back(1'b0);
      run(95, 0);
      n_checks++; if (se_c.size() !== 1 || se_c[0] !== 80) begin
         n_fail++; $display("FAIL break_stop_err got_n=%0d first=%0d exp=80", se_c.size(), se_c.size() ? se_c[0] : -1); end
      n_checks++; if (dv_c.size() + pe_c.size() !== 0) begin
         n_fail++; $display("FAIL break_other got=%0d exp=0", dv_c.size() + pe_c.size()); end
      n_checks++; if (bz_log[80] !== 1'b0) begin n_fail++; $display("FAIL break_idle got=%b exp=0", bz_log[80]); end
`endif
      n_checks++; if (data_out !== last_good) begin n_fail++; $display("FAIL break_hold got=%h exp=%h", data_out, last_good); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_parity;
      test_stop_error;
      test_glitch;
      test_back_to_back;
      test_reset_mid;
      test_min_prescale;
      test_random;
      test_break;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
